// File: rtl/bcd_serial_adder.sv
// Digit-serial multi-digit BCD adder: one digit pair per cycle through a single
// BCD digit cell, carry rippled through a register, LSD first, done pulse at end.

module bcd_digit_add (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_c,
    output logic [3:0] o_d,
    output logic       o_c
);
    logic [4:0] w_bin;
    logic [4:0] w_adj;

    // Binary sum plus decimal correction when it exceeds 9
    always_comb begin
        w_bin = 5'(i_a) + 5'(i_b) + 5'(i_c);
        w_adj = w_bin + 5'd6;
        if (w_bin > 5'd9) begin
            o_d = w_adj[3:0];
            o_c = 1'b1;
        end else begin
            o_d = w_bin[3:0];
            o_c = 1'b0;
        end
    end
endmodule

module bcd_serial_adder #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic [4*DIGITS-1:0]   i_a,
    input  logic [4*DIGITS-1:0]   i_b,
    input  logic                  i_c_in,
    output logic                  o_ready,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [4*DIGITS-1:0]   o_sum,
    output logic                  o_c_out,
    output logic                  o_err
);
    localparam int unsigned W     = 4 * DIGITS;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'b001,
        S_RUN  = 3'b010,
        S_DONE = 3'b100
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic [W-1:0]       r_sum;
    logic [IDX_W-1:0]   r_idx;
    logic               r_carry;
    logic               r_c_out;
    logic               r_err;
    logic               w_accept;
    logic               w_last;
    logic               w_err_in;
    logic [3:0]         w_dig;
    logic               w_dig_c;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_next = S_RUN;
            S_RUN:   if (w_last)  w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Moore outputs and control strobes
    always_comb begin
        o_ready  = (r_state == S_IDLE);
        o_busy   = (r_state == S_RUN);
        o_done   = (r_state == S_DONE);
        w_accept = (r_state == S_IDLE) && i_start;
        w_last   = (r_state == S_RUN) && (r_idx == IDX_W'(DIGITS - 1));
    end

    // Any operand digit above 9 marks the whole add invalid
    always_comb begin
        w_err_in = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (i_a[4*i +: 4] > 4'd9 || i_b[4*i +: 4] > 4'd9) w_err_in = 1'b1;
        end
    end

    bcd_digit_add u_cell (
        .i_a (r_a[4*r_idx +: 4]),
        .i_b (r_b[4*r_idx +: 4]),
        .i_c (r_carry),
        .o_d (w_dig),
        .o_c (w_dig_c)
    );

    // Operand latch, digit sequencing and result assembly
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_c_out <= 1'b0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= i_a;
            r_b     <= i_b;
            r_sum   <= '0;
            r_idx   <= '0;
            r_carry <= i_c_in;
            r_c_out <= 1'b0;
            r_err   <= w_err_in;
        end else if (r_state == S_RUN) begin
            r_carry <= w_dig_c;
            if (w_last) begin
                r_idx <= '0;
                if (r_err) begin
                    r_sum   <= '0;
                    r_c_out <= 1'b0;
                end else begin
                    r_sum[4*r_idx +: 4] <= w_dig;
                    r_c_out             <= w_dig_c;
                end
            end else begin
                r_sum[4*r_idx +: 4] <= w_dig;
                r_idx               <= r_idx + IDX_W'(1);
            end
        end
    end

    assign o_sum   = r_sum;
    assign o_c_out = r_c_out;
    assign o_err   = r_err;
endmodule

// File: tb/tb_bcd_serial_adder.sv
// Directed-vector bench for bcd_serial_adder with DIGITS=4.

module tb_bcd_serial_adder;
    localparam int unsigned DIGITS = 4;
    localparam int unsigned W      = 4 * DIGITS;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         i_start;
    logic [W-1:0] i_a;
    logic [W-1:0] i_b;
    logic         i_c_in;
    logic         o_ready;
    logic         o_busy;
    logic         o_done;
    logic [W-1:0] o_sum;
    logic         o_c_out;
    logic         o_err;

    int checks = 0;
    int errors = 0;

    bcd_serial_adder #(.DIGITS(DIGITS)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (i_start),
        .i_a     (i_a),
        .i_b     (i_b),
        .i_c_in  (i_c_in),
        .o_ready (o_ready),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_sum   (o_sum),
        .o_c_out (o_c_out),
        .o_err   (o_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Launch one add and follow it to completion; inputs are scrambled after acceptance
    task automatic do_add(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic [W-1:0] exp_sum,
                          input logic exp_cout, input logic exp_err);
        int n;
        int busy_cnt;
        i_a = a; i_b = b; i_c_in = cin; i_start = 1'b1;
        tick;
        i_start = 1'b0;
        i_a = '1; i_b = '1; i_c_in = ~cin;
        chk({tag, "_busy_t1"}, 32'(o_busy), 32'd1);
        chk({tag, "_err_t1"}, 32'(o_err), 32'(exp_err));
        chk({tag, "_sum_clr"}, 32'(o_sum), 32'd0);
        n = 1;
        busy_cnt = o_busy ? 1 : 0;
        while (!o_done && n < 20) begin
            tick;
            n++;
            if (o_busy) busy_cnt++;
        end
        chk({tag, "_latency"}, 32'(n), 32'(DIGITS + 1));
        chk({tag, "_busy_cnt"}, 32'(busy_cnt), 32'(DIGITS));
        chk({tag, "_sum"}, 32'(o_sum), 32'(exp_sum));
        chk({tag, "_cout"}, 32'(o_c_out), 32'(exp_cout));
        chk({tag, "_err"}, 32'(o_err), 32'(exp_err));
        tick;
        chk({tag, "_done_pulse"}, 32'(o_done), 32'd0);
        chk({tag, "_ready"}, 32'(o_ready), 32'd1);
        chk({tag, "_sum_hold"}, 32'(o_sum), 32'(exp_sum));
    endtask

    initial begin
        int dones;
        logic [W-1:0] cap;
        rst_n = 1'b0; i_start = 1'b0; i_a = '0; i_b = '0; i_c_in = 1'b0;
        tick; tick;
        chk("rst_ready", 32'(o_ready), 32'd1);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_sum", 32'(o_sum), 32'd0);
        chk("rst_cout", 32'(o_c_out), 32'd0);
        chk("rst_err", 32'(o_err), 32'd0);
        rst_n = 1'b1;
        tick;

        do_add("basic",   16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0);
        do_add("ripple",  16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_add("max",     16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0);
        do_add("cin",     16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);
        do_add("bad_a",   16'h12A4, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1);
        do_add("bad_b",   16'h0999, 16'hF000, 1'b1, 16'h0000, 1'b0, 1'b1);
        do_add("recover", 16'h0048, 16'h0052, 1'b0, 16'h0100, 1'b0, 1'b0);

        // Partial sum during RUN: only digit 0 written after the first RUN edge
        i_a = 16'h1234; i_b = 16'h5678; i_c_in = 1'b0; i_start = 1'b1;
        tick;
        i_start = 1'b0;
        tick;
        chk("partial_sum", 32'(o_sum), 32'h0002);
        for (int k = 0; k < 8; k++) tick;

        // Start pulsed while busy must be ignored
        i_a = 16'h0005; i_b = 16'h0005; i_c_in = 1'b0; i_start = 1'b1;
        tick;
        i_start = 1'b0; i_a = 16'h1111;
        i_start = 1'b1;
        tick;
        i_start = 1'b0;
        dones = 0; cap = '0;
        for (int k = 0; k < 12; k++) begin
            if (o_done) begin dones++; cap = o_sum; end
            tick;
        end
        chk("busy_start_dones", 32'(dones), 32'd1);
        chk("busy_start_sum", 32'(cap), 32'h0010);

        // Reset in the middle of an add
        i_a = 16'h0005; i_b = 16'h0005; i_start = 1'b1;
        tick;
        i_start = 1'b0;
        rst_n = 1'b0;
        tick;
        chk("midrst_ready", 32'(o_ready), 32'd1);
        chk("midrst_busy", 32'(o_busy), 32'd0);
        chk("midrst_sum", 32'(o_sum), 32'd0);
        rst_n = 1'b1;
        dones = 0;
        for (int k = 0; k < 8; k++) begin
            tick;
            if (o_done) dones++;
        end
        chk("midrst_no_done", 32'(dones), 32'd0);
        do_add("post_rst", 16'h0500, 16'h0500, 1'b0, 16'h1000, 1'b0, 1'b0);

        // start held high restarts right after returning to IDLE
        i_a = 16'h0001; i_b = 16'h0002; i_c_in = 1'b0; i_start = 1'b1;
        tick;
        dones = 0;
        while (!o_done && dones < 20) begin tick; dones++; end
        chk("hold_done", 32'(o_done), 32'd1);
        chk("hold_sum", 32'(o_sum), 32'h0003);
        tick;
        chk("hold_idle", 32'(o_ready), 32'd1);
        tick;
        chk("hold_restart", 32'(o_busy), 32'd1);
        i_start = 1'b0;
        for (int k = 0; k < 8; k++) tick;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
